// File: rtl/fa_step4.sv
// ---------------------------------------------------------------------------
// fa_step4 -- final stage of the pipelined 25-bit prefix adder in the FP MAC
// front end. Forms the raw sum from the propagate vector and the group
// generate vector, normalizes it (1-bit right shift on an addition carry-out,
// otherwise leading-zero left shift), adjusts the exponent and packs an
// IEEE-754 single-precision result with zero/overflow/underflow flags.
//
// Two register stages, latency 2, one operation accepted per cycle, no stall.
//
// Ports:
//   CLK        clock, rising edge
//   RESETn     asynchronous active-low reset
//   in_valid   in_* carry a live operation this cycle
//   in_sign    result sign
//   in_yn      effective subtraction (1) / addition (0)
//   in_ex      pre-normalization biased exponent
//   in_P0      bitwise propagate a^b
//   in_GG      group generate, GG[i] = carry out of bit i (GG[SUM_W-1] unused)
//   out_valid  out_result / flags valid
//   out_result packed {sign, exponent, fraction}
//   out_zero   result is exactly zero
//   out_ovf    exponent overflow, result forced to infinity
//   out_unf    exponent underflow, result flushed to signed zero
// ---------------------------------------------------------------------------
module fa_step4 #(
  parameter int EXP_W = 8,
  parameter int SUM_W = 25
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             in_valid,
  input  logic             in_sign,
  input  logic             in_yn,
  input  logic [EXP_W-1:0] in_ex,
  input  logic [SUM_W-1:0] in_P0,
  input  logic [SUM_W-1:0] in_GG,
  output logic             out_valid,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_unf
);

  localparam int MANT_W = SUM_W - 1;
  localparam int LZC_W  = $clog2(MANT_W + 1);
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

  // Stage A registers
  logic             r_valid;
  logic             r_sign;
  logic             r_yn;
  logic [EXP_W-1:0] r_ex;
  logic [SUM_W-1:0] r_sum;

  // Stage B combinational results
  logic [SUM_W-1:0]         w_sum;
  logic                     w_unused;
  logic                     w_carry;
  logic [LZC_W-1:0]         w_lzc;
  logic [MANT_W-1:0]        w_mant;
  logic signed [EXP_W+1:0]  w_exp;
  logic                     w_isZero;
  logic                     w_isOvf;
  logic                     w_isUnf;
  logic [31:0]              w_result;

  // Carry into bit i is the group generate of bit i-1; the top generate bit
  // would be the carry out of the whole vector and is not needed here.
  assign w_sum    = in_P0 ^ {in_GG[SUM_W-2:0], 1'b0};
  assign w_unused = in_GG[SUM_W-1];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_valid <= 1'b0;
      r_sign  <= 1'b0;
      r_yn    <= 1'b0;
      r_ex    <= '0;
      r_sum   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sign <= in_sign;
        r_yn   <= in_yn;
        r_ex   <= in_ex;
        r_sum  <= w_sum;
      end
    end
  end

  // Leading-zero count of the low MANT_W bits; ascending scan so the highest
  // set bit is the last one to write the count. All-zero leaves MANT_W.
  always_comb begin
    w_lzc = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (r_sum[i]) w_lzc = LZC_W'(MANT_W - 1 - i);
    end
  end

  // Only an addition with a carry-out takes the right-shift path; on a
  // subtraction the top sum bit is a discarded borrow artefact.
  assign w_carry = !r_yn && r_sum[SUM_W-1];

  always_comb begin
    if (w_carry) begin
      w_mant = r_sum[SUM_W-1:1];
      w_exp  = $signed({2'b00, r_ex}) + (EXP_W+2)'(1);
    end else begin
      w_mant = r_sum[MANT_W-1:0] << w_lzc;
      w_exp  = $signed({2'b00, r_ex}) - $signed((EXP_W+2)'(w_lzc));
    end
  end

  assign w_isZero = !w_carry && (r_sum[MANT_W-1:0] == '0);
  assign w_isOvf  = !w_isZero && (w_exp >= EXP_MAX);
  // Underflow when the signed exponent is negative or exactly zero.
  assign w_isUnf  = !w_isZero && !w_isOvf && (w_exp[EXP_W+1] || (w_exp == '0));

  always_comb begin
    if (w_isZero) begin
      w_result = 32'h0000_0000;
    end else if (w_isOvf) begin
      w_result = {r_sign, {EXP_W{1'b1}}, {(31-EXP_W){1'b0}}};
    end else if (w_isUnf) begin
      w_result = {r_sign, 31'h0};
    end else begin
      w_result = {r_sign, w_exp[EXP_W-1:0], w_mant[MANT_W-2:0]};
    end
  end

  // Output registers hold their last value across idle cycles.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_valid  <= 1'b0;
      out_result <= 32'h0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_unf    <= 1'b0;
    end else begin
      out_valid <= r_valid;
      if (r_valid) begin
        out_result <= w_result;
        out_zero   <= w_isZero;
        out_ovf    <= w_isOvf;
        out_unf    <= w_isUnf;
      end
    end
  end

endmodule

// File: tb/tb_fa_step4.sv
// ---------------------------------------------------------------------------
// Testbench for fa_step4: directed vectors with literal expectations plus a
// behavioural model compared against the outputs every falling edge.
// ---------------------------------------------------------------------------
module tb_fa_step4;

  logic        CLK;
  logic        RESETn;
  logic        in_valid;
  logic        in_sign;
  logic        in_yn;
  logic [7:0]  in_ex;
  logic [24:0] in_P0;
  logic [24:0] in_GG;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  int errorCount = 0;
  int checkCount = 0;

  fa_step4 #(.EXP_W(8), .SUM_W(25)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .in_valid  (in_valid),
    .in_sign   (in_sign),
    .in_yn     (in_yn),
    .in_ex     (in_ex),
    .in_P0     (in_P0),
    .in_GG     (in_GG),
    .out_valid (out_valid),
    .out_result(out_result),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: plain arithmetic on the sum value, returns
  // {zero, ovf, unf, result}.
  function automatic logic [34:0] modelOp(input logic sign, input logic yn,
                                          input logic [7:0] ex,
                                          input logic [24:0] p0,
                                          input logic [24:0] gg);
    longint s, v, mant;
    int     shift, e;
    s = (longint'(p0) ^ (longint'(gg) * 2)) % 64'd33554432;
    if (!yn && s >= 64'd16777216) begin
      mant = s / 2;
      e    = int'(ex) + 1;
    end else begin
      v = s % 64'd16777216;
      if (v == 0) return {3'b100, 32'h0};
      shift = 0;
      while (v < 64'd8388608) begin
        v = v * 2;
        shift++;
      end
      mant = v;
      e    = int'(ex) - shift;
    end
    if (e >= 255) return {3'b010, sign, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, sign, 31'h0};
    return {3'b000, sign, 8'(e), 23'(mant % 64'd8388608)};
  endfunction

  // Two-deep model pipeline mirroring the two-cycle latency; results hold
  // when no valid operation arrives.
  logic        mValidA;
  logic [34:0] mRecA;
  logic        expValid;
  logic [34:0] expRec;

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mValidA  <= 1'b0;
      mRecA    <= '0;
      expValid <= 1'b0;
      expRec   <= '0;
    end else begin
      expValid <= mValidA;
      if (mValidA) expRec <= mRecA;
      mValidA <= in_valid;
      if (in_valid) mRecA <= modelOp(in_sign, in_yn, in_ex, in_P0, in_GG);
    end
  end

  // Compare process on every falling edge.
  always @(negedge CLK) begin
    checkCount++;
    if ({out_valid, out_zero, out_ovf, out_unf, out_result} !== {expValid, expRec}) begin
      errorCount++;
      $display("[TB] FAIL model t=%0t got v=%b z=%b o=%b u=%b r=%08h want v=%b z=%b o=%b u=%b r=%08h",
               $time, out_valid, out_zero, out_ovf, out_unf, out_result,
               expValid, expRec[34], expRec[33], expRec[32], expRec[31:0]);
    end
  end

  task automatic applyStimulus(input logic v, input logic sign, input logic yn,
                               input logic [7:0] ex, input logic [24:0] p0,
                               input logic [24:0] gg);
    in_valid = v;
    in_sign  = sign;
    in_yn    = yn;
    in_ex    = ex;
    in_P0    = p0;
    in_GG    = gg;
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string name, input logic v, input logic [31:0] r,
                             input logic z, input logic o, input logic u);
    checkCount++;
    if ({out_valid, out_result, out_zero, out_ovf, out_unf} !== {v, r, z, o, u}) begin
      errorCount++;
      $display("[TB] FAIL %s got v=%b r=%08h z=%b o=%b u=%b want v=%b r=%08h z=%b o=%b u=%b",
               name, out_valid, out_result, out_zero, out_ovf, out_unf, v, r, z, o, u);
    end
  endtask

  task automatic runVector(input string name, input logic sign, input logic yn,
                           input logic [7:0] ex, input logic [24:0] p0,
                           input logic [24:0] gg, input logic [31:0] r,
                           input logic z, input logic o, input logic u);
    applyStimulus(1'b1, sign, yn, ex, p0, gg);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h0, 25'h0, 25'h0);
    checkOutput(name, 1'b1, r, z, o, u);
  endtask

  logic [4:0]  validPattern;
  logic [31:0] heldResult;

  initial begin
    RESETn   = 1'b0;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_yn    = 1'b0;
    in_ex    = 8'h0;
    in_P0    = 25'h0;
    in_GG    = 25'h0;
    repeat (2) @(negedge CLK);
    checkOutput("resetState", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    RESETn = 1'b1;
    @(negedge CLK);

    runVector("add1p1",      1'b0, 1'b0, 8'd127, 25'h0000000, 25'h0800000, 32'h40000000, 1'b0, 1'b0, 1'b0);
    runVector("subNorm",     1'b0, 1'b1, 8'd127, 25'h0000001, 25'h0000000, 32'h34000000, 1'b0, 1'b0, 1'b0);
    runVector("cancel",      1'b1, 1'b1, 8'd100, 25'h0000000, 25'h0000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
    runVector("overflow",    1'b0, 1'b0, 8'd254, 25'h0000000, 25'h0800000, 32'h7F800000, 1'b0, 1'b1, 1'b0);
    runVector("underflow",   1'b1, 1'b1, 8'd5,   25'h0000001, 25'h0000000, 32'h80000000, 1'b0, 1'b0, 1'b1);
    runVector("addNoCarry",  1'b0, 1'b0, 8'd130, 25'h0C00000, 25'h0000000, 32'h41400000, 1'b0, 1'b0, 1'b0);
    runVector("expOne",      1'b0, 1'b1, 8'd24,  25'h0000001, 25'h0000000, 32'h00800000, 1'b0, 1'b0, 1'b0);
    runVector("expZero",     1'b0, 1'b1, 8'd23,  25'h0000001, 25'h0000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
    runVector("subTopIgnored", 1'b1, 1'b1, 8'd50, 25'h0000000, 25'h0800000, 32'h00000000, 1'b1, 1'b0, 1'b0);
    runVector("mixedCarry",  1'b0, 1'b0, 8'd127, 25'h0123456, 25'h0000F0F, 32'h3E115240, 1'b0, 1'b0, 1'b0);

    // Three back-to-back operations, one bubble, one more operation.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd127, 25'h0000000, 25'h0800000);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd127, 25'h0000001, 25'h0000000);
    validPattern[4] = out_valid;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd130, 25'h0C00000, 25'h0000000);
    validPattern[3] = out_valid;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 25'h0, 25'h0);
    validPattern[2] = out_valid;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd100, 25'h0000100, 25'h0000000);
    validPattern[1] = out_valid;
    heldResult = out_result;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 25'h0, 25'h0);
    validPattern[0] = out_valid;
    checkOutput("throughputLast", 1'b1, 32'hAA800000, 1'b0, 1'b0, 1'b0);
    checkCount++;
    if (validPattern !== 5'b11101) begin
      errorCount++;
      $display("[TB] FAIL validPattern got %b want 11101", validPattern);
    end
    checkCount++;
    if (heldResult !== 32'h41400000) begin
      errorCount++;
      $display("[TB] FAIL bubbleHold got %08h want 41400000", heldResult);
    end

    // Reset asserted asynchronously while an operation sits in stage A.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd127, 25'h0000000, 25'h0800000);
    in_valid = 1'b0;
    #2 RESETn = 1'b0;
    #1 checkOutput("resetAsync", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    #2 RESETn = 1'b1;
    repeat (4) @(negedge CLK);
    checkOutput("noStale", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    runVector("afterReset",  1'b0, 1'b1, 8'd127, 25'h0000001, 25'h0000000, 32'h34000000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
